// File: rtl/eda_img_window_ram.sv
// M x N raster frame store serving registered 3x3 neighbourhood windows
// with border / connectivity masking and neighbour addresses.
module eda_img_window_ram #(
  parameter int M = 16,
  parameter int N = 16,
  parameter int PIXEL_WIDTH = 8,
  parameter logic [PIXEL_WIDTH-1:0] PAD_VALUE = '0,
  parameter int I_WIDTH = $clog2(M),
  parameter int J_WIDTH = $clog2(N),
  parameter int ADDR_WIDTH = I_WIDTH + J_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     load_start,
  input  logic                     pix_valid,
  output logic                     pix_ready,
  input  logic [PIXEL_WIDTH-1:0]   pixel_in,
  output logic                     load_done,
  output logic                     frame_ready,
  input  logic                     conn8,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_WIDTH-1:0]    req_addr,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ADDR_WIDTH-1:0]    center_addr_out,
  output logic [9*PIXEL_WIDTH-1:0] window_values,
  output logic [7:0]               neigh_valid,
  output logic [8*ADDR_WIDTH-1:0]  neigh_addr,
  output logic                     addr_err
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    READY
  } state_t;

  localparam logic [I_WIDTH-1:0] ROW_LAST = I_WIDTH'(M - 1);
  localparam logic [J_WIDTH-1:0] COL_LAST = J_WIDTH'(N - 1);
  localparam logic [I_WIDTH:0]   M_L = (I_WIDTH + 1)'(M);
  localparam logic [J_WIDTH:0]   N_L = (J_WIDTH + 1)'(N);
  localparam logic [I_WIDTH:0]   I_ONE = (I_WIDTH + 1)'(1);
  localparam logic [J_WIDTH:0]   J_ONE = (J_WIDTH + 1)'(1);

  state_t state, state_nx;

  logic [I_WIDTH-1:0]     row;
  logic [J_WIDTH-1:0]     col;
  logic [PIXEL_WIDTH-1:0] mem [(1 << ADDR_WIDTH)];

  logic pix_acc;
  logic last_pix;
  logic req_acc;

  assign pix_acc  = pix_valid && pix_ready;
  assign last_pix = pix_acc && (row == ROW_LAST) && (col == COL_LAST);
  assign req_acc  = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (load_start) state_nx = LOAD;
      LOAD: begin
        if (load_start)    state_nx = LOAD;
        else if (last_pix) state_nx = READY;
      end
      READY:   if (load_start) state_nx = LOAD;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    pix_ready   = (state == LOAD) && !load_start;
    frame_ready = (state == READY) && !load_start;
    req_ready   = frame_ready && (!rsp_valid || rsp_ready);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      row       <= '0;
      col       <= '0;
      load_done <= 1'b0;
    end else begin
      load_done <= last_pix;
      if (load_start || last_pix) begin
        row <= '0;
        col <= '0;
      end else if (pix_acc) begin
        if (col == COL_LAST) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (pix_acc) mem[{row, col}] <= pixel_in;
  end

  // guard bit: borrow on i-1 / j-1 marks the top/left border
  logic [I_WIDTH:0] ci, im1, ip1;
  logic [J_WIDTH:0] cj, jm1, jp1;
  logic             err_d;
  logic [2:0]       rv, cv;
  logic [I_WIDTH-1:0] ra [3];
  logic [J_WIDTH-1:0] ca [3];

  assign ci    = {1'b0, req_addr[ADDR_WIDTH-1:J_WIDTH]};
  assign cj    = {1'b0, req_addr[J_WIDTH-1:0]};
  assign im1   = ci - I_ONE;
  assign ip1   = ci + I_ONE;
  assign jm1   = cj - J_ONE;
  assign jp1   = cj + J_ONE;
  assign err_d = (ci >= M_L) || (cj >= N_L);
  assign rv    = {ip1 < M_L, 1'b1, !im1[I_WIDTH]};
  assign cv    = {jp1 < N_L, 1'b1, !jm1[J_WIDTH]};

  always_comb begin
    ra[0] = im1[I_WIDTH-1:0];
    ra[1] = ci[I_WIDTH-1:0];
    ra[2] = ip1[I_WIDTH-1:0];
    ca[0] = jm1[J_WIDTH-1:0];
    ca[1] = cj[J_WIDTH-1:0];
    ca[2] = jp1[J_WIDTH-1:0];
  end

  wire [9*PIXEL_WIDTH-1:0] win_d;
  wire [7:0]               nv_d;
  wire [8*ADDR_WIDTH-1:0]  na_d;

  for (genvar r = 0; r < 3; r++) begin : g_r
    for (genvar c = 0; c < 3; c++) begin : g_c
      localparam int K = r * 3 + c;
      localparam bit ORTHO = (r == 1) || (c == 1);
      logic                  v;
      logic [ADDR_WIDTH-1:0] a;
      assign v = rv[r] && cv[c] && !err_d && (conn8 || ORTHO);
      assign a = v ? {ra[r], ca[c]} : '0;
      assign win_d[(8-K)*PIXEL_WIDTH +: PIXEL_WIDTH] =
        v ? mem[a] : PAD_VALUE;
      if (K != 4) begin : g_n
        localparam int B = (K < 4) ? 7 - K : 8 - K;
        assign nv_d[B] = v;
        assign na_d[B*ADDR_WIDTH +: ADDR_WIDTH] = a;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rsp_valid       <= 1'b0;
      center_addr_out <= '0;
      window_values   <= '0;
      neigh_valid     <= '0;
      neigh_addr      <= '0;
      addr_err        <= 1'b0;
    end else if (req_acc) begin
      rsp_valid       <= 1'b1;
      center_addr_out <= req_addr;
      window_values   <= win_d;
      neigh_valid     <= nv_d;
      neigh_addr      <= na_d;
      addr_err        <= err_d;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_eda_img_window_ram.sv
// Scoreboard bench for eda_img_window_ram: 16x16 random traffic
// against a reference image model, plus a 5x7 border build.
module tb_eda_img_window_ram;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        load_start, pix_valid, pix_ready;
  logic [7:0]  pixel_in;
  logic        load_done, frame_ready, conn8;
  logic        req_valid, req_ready, rsp_valid, rsp_ready;
  logic [7:0]  req_addr, center_addr_out;
  logic [71:0] window_values;
  logic [7:0]  neigh_valid;
  logic [63:0] neigh_addr;
  logic        addr_err;

  logic        s_load_start, s_pix_valid, s_pix_ready;
  logic [7:0]  s_pixel_in;
  logic        s_load_done, s_frame_ready, s_conn8;
  logic        s_req_valid, s_req_ready, s_rsp_valid, s_rsp_ready;
  logic [5:0]  s_req_addr, s_center;
  logic [71:0] s_win;
  logic [7:0]  s_nv;
  logic [47:0] s_na;
  logic        s_err;

  always #5 clk = ~clk;

  eda_img_window_ram #(.M(16), .N(16)) dut (
    .clk(clk), .reset_n(reset_n), .load_start(load_start),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pixel_in(pixel_in), .load_done(load_done),
    .frame_ready(frame_ready), .conn8(conn8),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .center_addr_out(center_addr_out),
    .window_values(window_values), .neigh_valid(neigh_valid),
    .neigh_addr(neigh_addr), .addr_err(addr_err)
  );

  eda_img_window_ram #(.M(5), .N(7)) dut_s (
    .clk(clk), .reset_n(reset_n), .load_start(s_load_start),
    .pix_valid(s_pix_valid), .pix_ready(s_pix_ready),
    .pixel_in(s_pixel_in), .load_done(s_load_done),
    .frame_ready(s_frame_ready), .conn8(s_conn8),
    .req_valid(s_req_valid), .req_ready(s_req_ready),
    .req_addr(s_req_addr), .rsp_valid(s_rsp_valid),
    .rsp_ready(s_rsp_ready), .center_addr_out(s_center),
    .window_values(s_win), .neigh_valid(s_nv),
    .neigh_addr(s_na), .addr_err(s_err)
  );

  typedef struct {
    logic [7:0]  c;
    logic [71:0] win;
    logic [7:0]  nv;
    logic [63:0] na;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   img [16][16];
  int   cnt;
  int   errors = 0;
  int   checks = 0;
  bit   rnd_rdy = 0;

  task automatic check(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t model(input int i, input int j, input bit c8);
    exp_t e;
    int   b, ni, nj;
    bit   err, v;
    e.c = 8'((i << 4) | j);
    e.win = '0;
    e.nv = '0;
    e.na = '0;
    err = (i >= 16) || (j >= 16);
    e.err = err;
    b = 7;
    for (int di = -1; di <= 1; di++) begin
      for (int dj = -1; dj <= 1; dj++) begin
        ni = i + di;
        nj = j + dj;
        v = !err && ni >= 0 && ni < 16 && nj >= 0 && nj < 16;
        if (di != 0 && dj != 0 && !c8) v = 0;
        if (v) e.win[(8 - ((di + 1) * 3 + dj + 1)) * 8 +: 8] = 8'(img[ni][nj]);
        if (di != 0 || dj != 0) begin
          e.nv[b] = v;
          if (v) e.na[b*8 +: 8] = 8'((ni << 4) | nj);
          b--;
        end
      end
    end
    return e;
  endfunction

  // monitor: every presented response is compared; popped on handshake
  always @(negedge clk) begin
    if (reset_n && rsp_valid) begin
      if (q.size() == 0) begin
        check("rsp_unexpected", 1, 0);
      end else begin
        check("rsp_center", center_addr_out, q[0].c);
        check("rsp_window", window_values, q[0].win);
        check("rsp_nvalid", neigh_valid, q[0].nv);
        check("rsp_naddr", neigh_addr, q[0].na);
        check("rsp_err", addr_err, q[0].err);
        if (rsp_ready) void'(q.pop_front());
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_rdy) rsp_ready = 1'($urandom_range(0, 1));
  end

  task automatic do_req(input logic [7:0] a, input bit c8, output int w);
    req_valid = 1;
    req_addr = a;
    conn8 = c8;
    w = 0;
    @(negedge clk);
    while (!req_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) check("req_timeout", 0, 1);
    else q.push_back(model(int'(a[7:4]), int'(a[3:0]), c8));
    @(posedge clk);
    #1;
  endtask

  task automatic load_px(input int n, input bit pat, input bit full);
    bit bad, early;
    int w, v;
    bad = 0;
    early = 0;
    for (int k = 0; k < n; k++) begin
      v = pat ? (((cnt / 16) * 16 + cnt % 16) & 255)
              : int'($urandom_range(0, 255));
      pix_valid = 1;
      pixel_in = 8'(v);
      w = 0;
      @(negedge clk);
      while (!pix_ready && w < 100) begin
        @(negedge clk);
        w++;
      end
      if (w >= 100) bad = 1;
      if (load_done || frame_ready) early = 1;
      img[cnt / 16][cnt % 16] = v;
      cnt++;
      @(posedge clk);
      #1;
    end
    pix_valid = 0;
    check("pix_accept", bad, 0);
    check("load_done_early", early, 0);
    if (full) begin
      @(negedge clk);
      check("load_done", load_done, 1);
      check("frame_ready", frame_ready, 1);
      check("pix_ready_after", pix_ready, 0);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("load_done_pulse", load_done, 0);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic s_req(input logic [5:0] a, input bit c8);
    s_req_valid = 1;
    s_req_addr = a;
    s_conn8 = c8;
    @(negedge clk);
    check("s_req_ready", s_req_ready, 1);
    @(posedge clk);
    #1;
    s_req_valid = 0;
    @(negedge clk);
    check("s_rsp_valid", s_rsp_valid, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int  w;
    bit  slow;
    reset_n = 0;
    {load_start, pix_valid, pixel_in, conn8, req_valid, req_addr} = '0;
    rsp_ready = 1;
    {s_load_start, s_pix_valid, s_pixel_in, s_conn8} = '0;
    {s_req_valid, s_req_addr} = '0;
    s_rsp_ready = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_pix_ready", pix_ready, 0);
    check("rst_load_done", load_done, 0);
    check("rst_frame_ready", frame_ready, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_fields", {window_values, neigh_valid, addr_err}, 0);
    check("rst_addrs", {neigh_addr, center_addr_out}, 0);
    @(posedge clk);
    #1;
    reset_n = 1;

    load_start = 1;
    @(posedge clk);
    #1;
    load_start = 0;
    cnt = 0;
    load_px(100, 0, 0);
    load_start = 1;
    pix_valid = 1;
    @(negedge clk);
    check("restart_pix_ready", pix_ready, 0);
    @(posedge clk);
    #1;
    load_start = 0;
    pix_valid = 0;
    cnt = 0;
    load_px(256, 1, 1);

    do_req({4'd0, 4'd0}, 1, w);
    do_req({4'd15, 4'd15}, 1, w);
    do_req({4'd5, 4'd5}, 0, w);
    req_valid = 0;
    repeat (3) @(posedge clk);
    #1;

    // hold: second request blocked until the first response drains
    rsp_ready = 0;
    do_req({4'd7, 4'd3}, 1, w);
    req_addr = {4'd0, 4'd9};
    conn8 = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("hold_req_ready", req_ready, 0);
      @(posedge clk);
      #1;
    end
    rsp_ready = 1;
    do_req({4'd0, 4'd9}, 0, w);
    check("hold_release_wait", w, 0);
    req_valid = 0;
    repeat (2) @(posedge clk);
    #1;

    slow = 0;
    for (int k = 0; k < 8; k++) begin
      do_req(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), w);
      if (w != 0) slow = 1;
    end
    req_valid = 0;
    check("throughput", slow, 0);

    rnd_rdy = 1;
    for (int k = 0; k < 150; k++) begin
      repeat ($urandom_range(0, 2)) begin
        req_valid = 0;
        @(posedge clk);
        #1;
      end
      do_req(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), w);
    end
    req_valid = 0;
    rnd_rdy = 0;
    rsp_ready = 1;
    repeat (3) @(posedge clk);
    #1;

    // pending response survives a new load_start
    rsp_ready = 0;
    do_req({4'd1, 4'd14}, 1, w);
    req_valid = 0;
    load_start = 1;
    @(negedge clk);
    check("ls_rsp_valid", rsp_valid, 1);
    check("ls_frame_ready", frame_ready, 0);
    @(posedge clk);
    #1;
    load_start = 0;
    @(negedge clk);
    check("ls_rsp_hold", rsp_valid, 1);
    check("ls_req_ready", req_ready, 0);
    @(posedge clk);
    #1;
    rsp_ready = 1;
    cnt = 0;
    load_px(256, 0, 1);
    check("sb_drained", q.size(), 0);

    rnd_rdy = 1;
    for (int k = 0; k < 60; k++)
      do_req(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), w);
    req_valid = 0;
    rnd_rdy = 0;
    rsp_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", q.size(), 0);

    rsp_ready = 0;
    do_req({4'd8, 4'd8}, 1, w);
    req_valid = 0;
    @(negedge clk);
    @(posedge clk);
    #1;
    reset_n = 0;
    @(posedge clk);
    #1;
    reset_n = 1;
    q.delete();
    rsp_ready = 1;
    @(negedge clk);
    check("mrst_rsp_valid", rsp_valid, 0);
    check("mrst_frame_ready", frame_ready, 0);
    check("mrst_req_ready", req_ready, 0);
    @(posedge clk);
    #1;

    s_load_start = 1;
    @(posedge clk);
    #1;
    s_load_start = 0;
    slow = 0;
    for (int k = 0; k < 35; k++) begin
      s_pix_valid = 1;
      s_pixel_in = 8'(k);
      @(negedge clk);
      if (!s_pix_ready) slow = 1;
      @(posedge clk);
      #1;
    end
    s_pix_valid = 0;
    check("s_pix_accept", slow, 0);
    @(negedge clk);
    check("s_load_done", s_load_done, 1);
    check("s_frame_ready", s_frame_ready, 1);
    @(posedge clk);
    #1;

    s_req({3'd5, 3'd0}, 1);
    check("s_err_row", s_err, 1);
    check("s_err_nv", s_nv, 0);
    check("s_err_win", s_win, 0);
    check("s_err_na", s_na, 0);
    @(posedge clk);
    #1;
    s_req({3'd0, 3'd7}, 1);
    check("s_err_col", s_err, 1);
    check("s_err_col_win", s_win, 0);
    @(posedge clk);
    #1;
    s_req({3'd4, 3'd6}, 1);
    check("s_corner_err", s_err, 0);
    check("s_corner_nv", s_nv, 8'b11010000);
    check("s_corner_win", s_win,
          {8'd26, 8'd27, 8'd0, 8'd33, 8'd34, 8'd0, 8'd0, 8'd0, 8'd0});
    check("s_corner_na", s_na,
          {3'd3, 3'd5, 3'd3, 3'd6, 6'd0, 3'd4, 3'd5, 24'd0});
    check("s_corner_center", s_center, {3'd4, 3'd6});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
